// File: rtl/bram_tester.sv
// Two-pass BRAM self-test: writes an arithmetic pattern, reads it back, then repeats with the
// inverted pattern. Reports the first failing address and pass.
`timescale 1ns/1ps
module bram_tester #(
    parameter int unsigned ADDR_SZ = 8,
    parameter int unsigned DATA_SZ = 16,
    parameter int unsigned SEED    = 5,
    parameter int unsigned STEP    = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    output logic               o_wr_en,
    output logic [ADDR_SZ-1:0] o_waddr,
    output logic [DATA_SZ-1:0] o_wdata,
    output logic               o_rd_en,
    output logic [ADDR_SZ-1:0] o_raddr,
    input  logic [DATA_SZ-1:0] i_rdata,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [ADDR_SZ-1:0] o_err_addr,
    output logic               o_err_phase
);

    typedef enum logic [2:0] {StIdle, StWr0, StRd0, StWr1, StRd1, StDone} state_e;

    localparam logic [ADDR_SZ-1:0] LastAddr = '1;

    function automatic logic [DATA_SZ-1:0] pattern(input logic [ADDR_SZ-1:0] a);
        logic [DATA_SZ-1:0] av;
        av = DATA_SZ'(a);
        return DATA_SZ'(SEED) + av * DATA_SZ'(STEP);
    endfunction

    state_e             state_q;
    logic [ADDR_SZ-1:0] cnt_q;
    logic [ADDR_SZ-1:0] cnt_inc;
    // Read issued last cycle: its data is on i_rdata now.
    logic               cmp_valid_q;
    logic [ADDR_SZ-1:0] cmp_addr_q;
    logic [DATA_SZ-1:0] exp_data;
    logic               mismatch;

    always_comb begin
        cnt_inc  = cnt_q + 1'b1;
        exp_data = (state_q == StRd1) ? ~pattern(cmp_addr_q) : pattern(cmp_addr_q);
        mismatch = cmp_valid_q && (i_rdata != exp_data);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            o_wr_en     <= 1'b0;
            o_waddr     <= '0;
            o_wdata     <= '0;
            o_rd_en     <= 1'b0;
            o_raddr     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_err_addr  <= '0;
            o_err_phase <= 1'b0;
        end else begin
            cmp_valid_q <= o_rd_en;
            cmp_addr_q  <= o_raddr;
            unique case (state_q)
                StIdle, StDone: begin
                    if (i_start) begin
                        o_done      <= 1'b0;
                        o_pass      <= 1'b0;
                        o_err_addr  <= '0;
                        o_err_phase <= 1'b0;
                        o_busy      <= 1'b1;
                        o_wr_en     <= 1'b1;
                        o_waddr     <= '0;
                        o_wdata     <= pattern('0);
                        cnt_q       <= '0;
                        state_q     <= StWr0;
                    end
                end
                StWr0, StWr1: begin
                    if (cnt_q == LastAddr) begin
                        o_wr_en <= 1'b0;
                        o_rd_en <= 1'b1;
                        o_raddr <= '0;
                        cnt_q   <= '0;
                        state_q <= (state_q == StWr0) ? StRd0 : StRd1;
                    end else begin
                        cnt_q   <= cnt_inc;
                        o_waddr <= cnt_inc;
                        o_wdata <= (state_q == StWr0) ? pattern(cnt_inc) : ~pattern(cnt_inc);
                    end
                end
                StRd0, StRd1: begin
                    if (mismatch) begin
                        o_rd_en     <= 1'b0;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                        o_pass      <= 1'b0;
                        o_err_addr  <= cmp_addr_q;
                        o_err_phase <= (state_q == StRd1);
                        state_q     <= StDone;
                    end else if (o_rd_en) begin
                        if (cnt_q == LastAddr) begin
                            o_rd_en <= 1'b0;
                        end else begin
                            cnt_q   <= cnt_inc;
                            o_raddr <= cnt_inc;
                        end
                    end else if (state_q == StRd0) begin
                        // Drain compare for the last address passed: start the inverted pass.
                        o_wr_en <= 1'b1;
                        o_waddr <= '0;
                        o_wdata <= ~pattern('0);
                        cnt_q   <= '0;
                        state_q <= StWr1;
                    end else begin
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        o_pass  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assert property (@(posedge i_clk) disable iff (i_rst) !(o_wr_en && o_rd_en));

endmodule

// File: tb/tb_bram_tester.sv
// Randomised self-check of bram_tester against a cycle-indexed behavioural model and a
// faulty-BRAM model with one-cycle read latency.
`timescale 1ns/1ps
module tb_bram_tester;

    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int N    = 1 << AW;
    localparam int SEED = 5;
    localparam int STEP = 5;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b1;
    logic          o_wr_en, o_rd_en, o_busy, o_done, o_pass, o_err_phase;
    logic [AW-1:0] o_waddr, o_raddr, o_err_addr;
    logic [DW-1:0] o_wdata, i_rdata;

    bram_tester #(.ADDR_SZ(AW), .DATA_SZ(DW), .SEED(SEED), .STEP(STEP)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .o_wr_en(o_wr_en), .o_waddr(o_waddr), .o_wdata(o_wdata),
        .o_rd_en(o_rd_en), .o_raddr(o_raddr), .i_rdata(i_rdata),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
        .o_err_addr(o_err_addr), .o_err_phase(o_err_phase)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int a);
        return DW'(SEED + a * STEP);
    endfunction

    // BRAM model with optional stuck-at faults on one address
    logic [DW-1:0] mem [N];
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_s0 = '0;
    logic [DW-1:0] f_s1 = '0;

    function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] v);
        return (AW'(a) == f_addr) ? ((v & ~f_s0) | f_s1) : v;
    endfunction

    always @(posedge i_clk) begin
        if (o_wr_en) mem[o_waddr] <= o_wdata;
        if (o_rd_en) i_rdata <= faulty(int'(o_raddr), mem[o_raddr]);
    end

    // Reference model: outputs as a function of cycle index k within a run
    logic          e_wr, e_rd, e_busy, e_done, e_pass, e_phase;
    logic [AW-1:0] e_waddr, e_raddr, e_err;
    logic [DW-1:0] e_wdata;
    logic          m_active, m_fail, m_fp;
    int            m_k, m_end, m_fa;

    task automatic model_cycle();
        if (m_k >= m_end) begin
            e_busy = 0; e_done = 1; e_pass = !m_fail;
            e_err = m_fail ? AW'(m_fa) : '0;
            e_phase = m_fail ? m_fp : 1'b0;
            e_wr = 0; e_rd = 0; m_active = 0;
        end else begin
            e_busy = 1; e_wr = 0; e_rd = 0;
            if (m_k >= 1 && m_k <= N) begin
                e_wr = 1; e_waddr = AW'(m_k - 1); e_wdata = pat(m_k - 1);
            end else if (m_k >= 2*N+2 && m_k <= 3*N+1) begin
                e_wr = 1; e_waddr = AW'(m_k - 2*N - 2); e_wdata = ~pat(m_k - 2*N - 2);
            end
            if (m_k >= N+1 && m_k <= 2*N) begin
                e_rd = 1; e_raddr = AW'(m_k - N - 1);
            end else if (m_k >= 3*N+2 && m_k <= 4*N+1) begin
                e_rd = 1; e_raddr = AW'(m_k - 3*N - 2);
            end
        end
    endtask

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_active = 0; m_k = 0;
            e_wr = 0; e_rd = 0; e_busy = 0; e_done = 0; e_pass = 0; e_phase = 0;
            e_waddr = '0; e_raddr = '0; e_err = '0; e_wdata = '0;
        end else if (!e_busy && i_start) begin
            m_fail = 0; m_fp = 0; m_fa = 0;
            for (int p = 0; p < 2; p++) begin
                for (int a = 0; a < N; a++) begin
                    logic [DW-1:0] ev;
                    ev = (p == 1) ? ~pat(a) : pat(a);
                    if (!m_fail && faulty(a, ev) != ev) begin
                        m_fail = 1; m_fp = (p == 1); m_fa = a;
                    end
                end
            end
            // Run ends the cycle after the failing compare, or after the last drain compare
            m_end = !m_fail ? 4*N+3 : (m_fp ? 3*N+4+m_fa : N+3+m_fa);
            e_done = 0; e_pass = 0; e_err = '0; e_phase = 0;
            m_k = 1; m_active = 1;
            model_cycle();
        end else if (m_active) begin
            m_k++;
            model_cycle();
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("wr_en", o_wr_en, e_wr);
            chk("rd_en", o_rd_en, e_rd);
            chk("waddr", o_waddr, e_waddr);
            chk("wdata", o_wdata, e_wdata);
            chk("raddr", o_raddr, e_raddr);
            chk("busy", o_busy, e_busy);
            chk("done", o_done, e_done);
            chk("pass", o_pass, e_pass);
            chk("err_addr", o_err_addr, e_err);
            chk("err_phase", o_err_phase, e_phase);
        end
    end

    task automatic tick();
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start_run();
        i_start = 1'b1;
        cyc = 0;
        tick();
        i_start = 1'b0;
    endtask

    task automatic set_fault(input int a, input logic [DW-1:0] s0, input logic [DW-1:0] s1);
        f_addr = AW'(a); f_s0 = s0; f_s1 = s1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (errors so far %0d)", errors);
        $fatal(1);
    end

    initial begin
        // 1: reset held with start high
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk_en = 1'b1;
            chk("rst wr_en", o_wr_en, 0);
            chk("rst rd_en", o_rd_en, 0);
            chk("rst busy", o_busy, 0);
        end
        i_rst = 1'b0;
        i_start = 1'b0;
        tick(); tick();
        chk("idle done", o_done, 0);

        // 2: good memory
        start_run();
        chk("s2 wr_en c1", o_wr_en, 1);
        chk("s2 wdata c1", o_wdata, 16'h0005);
        run_to(16);
        chk("s2 waddr c16", o_waddr, 15);
        chk("s2 wdata c16", o_wdata, 16'h0050);
        run_to(17);
        chk("s2 rd_en c17", o_rd_en, 1);
        chk("s2 wr_en c17", o_wr_en, 0);
        run_to(33);
        chk("s2 rd_en c33", o_rd_en, 0);
        run_to(34);
        chk("s2 wdata c34", o_wdata, 16'hFFFA);
        run_to(49);
        chk("s2 wdata c49", o_wdata, 16'hFFAF);
        run_to(66);
        chk("s2 busy c66", o_busy, 1);
        run_to(67);
        chk("s2 busy c67", o_busy, 0);
        chk("s2 done c67", o_done, 1);
        chk("s2 pass c67", o_pass, 1);
        run_to(70);

        // 3: bit0 stuck-at-0 at address 3
        set_fault(3, 16'h0001, 16'h0000);
        start_run();
        run_to(53);
        chk("s3 rd_en c53", o_rd_en, 1);
        chk("s3 raddr c53", o_raddr, 3);
        run_to(55);
        chk("s3 done c55", o_done, 1);
        chk("s3 pass c55", o_pass, 0);
        chk("s3 err_addr c55", o_err_addr, 3);
        chk("s3 err_phase c55", o_err_phase, 1);
        chk("s3 rd_en c55", o_rd_en, 0);
        run_to(60);

        // 4: address 0 reads as zero
        set_fault(0, 16'hFFFF, 16'h0000);
        start_run();
        chk("s4 err_addr cleared", o_err_addr, 0);
        chk("s4 done cleared", o_done, 0);
        run_to(18);
        chk("s4 busy c18", o_busy, 1);
        run_to(19);
        chk("s4 done c19", o_done, 1);
        chk("s4 pass c19", o_pass, 0);
        chk("s4 err_addr c19", o_err_addr, 0);
        chk("s4 err_phase c19", o_err_phase, 0);
        chk("s4 busy c19", o_busy, 0);
        run_to(22);

        // 5: start while busy is ignored; start in DONE restarts
        set_fault(0, 16'h0000, 16'h0000);
        start_run();
        run_to(10);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        run_to(67);
        chk("s5 done c67", o_done, 1);
        chk("s5 pass c67", o_pass, 1);
        run_to(70);
        start_run();
        chk("s5 restart wr_en", o_wr_en, 1);
        chk("s5 restart done", o_done, 0);
        run_to(67);
        chk("s5 restart pass", o_pass, 1);
        run_to(69);

        // 6: reset mid-WR0
        start_run();
        run_to(10);
        i_rst = 1'b1;
        tick();
        chk("s6 wr_en c11", o_wr_en, 0);
        chk("s6 waddr c11", o_waddr, 0);
        chk("s6 busy c11", o_busy, 0);
        i_rst = 1'b0;
        run_to(20);
        chk("s6 wr_en c20", o_wr_en, 0);
        start_run();
        chk("s6 rerun waddr", o_waddr, 0);
        run_to(66);
        chk("s6 rerun busy c66", o_busy, 1);
        run_to(67);
        chk("s6 rerun pass", o_pass, 1);
        run_to(69);

        // Randomised faults with start noise while busy
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                set_fault(0, 16'h0000, 16'h0000);
            end else begin
                logic [DW-1:0] s1;
                s1 = ($urandom_range(0, 1) == 0) ? 16'h0000 : DW'(1 << $urandom_range(0, 15));
                set_fault(int'($urandom_range(0, N-1)), DW'(1 << $urandom_range(0, 15)), s1);
            end
            start_run();
            for (int w = 0; w < 4*N+10 && !o_done; w++) begin
                i_start = o_busy && ($urandom_range(0, 7) == 0);
                tick();
            end
            i_start = 1'b0;
            chk("rand completes", o_done, 1);
            tick(); tick();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_tester.md
Name: bram_tester

Overview:
- Self-test sequencer that sits directly upstream of the bram block and drives its write and read ports.
- Runs a two-pass pattern test over every address, checking each readback against the expected value:
  - pass 0 writes a true arithmetic pattern, then reads it back;
  - pass 1 writes the inverted pattern, then reads it back.
- Reports busy, done, pass/fail and the first failing address. A top-level wrapper maps these to the Fomu RGB LEDs.

Parameters:
- ADDR_SZ, 8, BRAM address width; N = 2^ADDR_SZ words tested.
- DATA_SZ, 16, BRAM data width.
- SEED, 5, pattern value at address 0.
- STEP, 5, pattern increment per address.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start request, sampled on rising edge
- o_wr_en  out  1  BRAM write enable
- o_waddr  out  ADDR_SZ  BRAM write address
- o_wdata  out  DATA_SZ  BRAM write data
- o_rd_en  out  1  BRAM read enable
- o_raddr  out  ADDR_SZ  BRAM read address
- i_rdata  in  DATA_SZ  BRAM read data, valid the cycle after o_rd_en
- o_busy  out  1  test in progress
- o_done  out  1  test finished
- o_pass  out  1  test passed (meaningful only while o_done=1)
- o_err_addr  out  ADDR_SZ  first failing address
- o_err_phase  out  1  pass in which the failure occurred (0 = true, 1 = inverted)

Behaviour:
- Interface: one clock; reset is synchronous and active-high (i_clk, i_rst).
- All outputs are registered. Reset value of every output is 0. State after reset is IDLE.
- Reset mid-operation: on the edge where i_rst=1 is sampled, all outputs go to 0 and state goes to IDLE. No further o_wr_en/o_rd_en pulses follow.
- pattern(a) = (SEED + a*STEP) mod 2^DATA_SZ. Arithmetic wraps silently.
- The inverted pass uses ~pattern(a).
- States: IDLE, WR0, RD0, WR1, RD1, DONE.
- IDLE / DONE + i_start=1 at edge of cycle 0:
  - clear o_done, o_pass, o_err_addr, o_err_phase;
  - set o_busy=1 from cycle 1;
  - enter WR0.
- i_start is ignored while o_busy=1.
- WR0, cycles 1..N: o_wr_en=1, o_waddr=a, o_wdata=pattern(a), for a = 0..N-1 in order.
- RD0:
  - cycles N+1..2N: o_rd_en=1, o_raddr=a for a = 0..N-1;
  - cycle N+1+a+1: i_rdata is compared with pattern(a);
  - cycle 2N+1: drain compare only, no o_rd_en.
- WR1, cycles 2N+2..3N+1: same as WR0 with ~pattern(a).
- RD1, cycles 3N+2..4N+1: reads; final compare at cycle 4N+2.
- Success: in cycle 4N+3, o_busy=0, o_done=1, o_pass=1. State goes to DONE.
- Mismatch on the compare for address a in pass p:
  - abort immediately; remaining reads are not issued;
  - from the next cycle, o_wr_en=o_rd_en=0, o_busy=0, o_done=1, o_pass=0, o_err_addr=a, o_err_phase=p;
  - state goes to DONE.
- DONE holds all result outputs until reset or the next accepted i_start.
- Outside their phases, o_wr_en=o_rd_en=0 and the address/data outputs hold their last value.
- o_wr_en and o_rd_en are never high in the same cycle.
- Phase end is detected by address counter == N-1, not by counter overflow. The counter returns to 0 at each phase start.

Test Plan:
Bench setup: ADDR_SZ=4 (N=16), DATA_SZ=16, SEED=5, STEP=5; behavioural BRAM model with 1-cycle read latency.
1. Reset: hold i_rst 3 cycles with i_start=1 -> all outputs 0, no wr/rd pulses.
2. Good memory: i_start pulse in cycle 0 ->
   - o_wr_en high cycles 1..16; o_waddr 0..15; o_wdata 0x0005, 0x000A .. 0x0050;
   - o_rd_en high cycles 17..32;
   - inverted writes cycles 34..49, o_wdata 0xFFFA .. 0xFFAF;
   - o_busy high cycles 1..66;
   - o_done=1, o_pass=1 from cycle 67.
3. Bit0 stuck-at-0 at address 3 (pattern(3)=0x0014 passes pass 0) ->
   - pass-1 read of address 3 issued in cycle 53, compared in cycle 54;
   - cycle 55: o_done=1, o_pass=0, o_err_addr=3, o_err_phase=1;
   - no o_rd_en after cycle 54.
4. Data fault at address 0 in pass 0 (model returns 0x0000) -> o_done=1, o_pass=0, o_err_addr=0, o_err_phase=0 in cycle 19; o_busy low in cycle 19.
5. i_start re-pulsed at cycle 10 -> ignored; completion timing identical to scenario 2. i_start in DONE -> result cleared, new run with o_wr_en high 1 cycle later.
6. i_rst asserted in cycle 10 (mid-WR0) -> cycle 11: all outputs 0, no further writes. A later i_start runs a full 67-cycle test from address 0.
